// File: rtl/ysyx_22050598_wb_pkg.sv
// Shared sizes and the writeback request payload for the RF writeback arbiter.
package ysyx_22050598_wb_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned NREG    = 32;
    localparam int unsigned REG_AW  = $clog2(NREG);
    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    // One result headed for the register file.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage : ysyx_22050598_wb_pkg

// File: rtl/ysyx_22050598_wb_arbiter_if.sv
// Issue, ALU/LSU result, RF write and busy-feedback signals of the writeback arbiter.
interface ysyx_22050598_wb_arbiter_if;
    import ysyx_22050598_wb_pkg::*;

    logic                    iss_valid;
    logic [REG_AW-1:0]       iss_rd;
    logic                    iss_ready;

    logic                    alu_valid;
    logic [REG_AW-1:0]       alu_rd;
    logic [XLEN-1:0]         alu_data;
    logic                    alu_ready;

    logic                    lsu_valid;
    logic [REG_AW-1:0]       lsu_rd;
    logic [XLEN-1:0]         lsu_data;
    logic                    lsu_ready;

    logic                    rf_wen;
    logic [REG_AW-1:0]       rf_waddr;
    logic [XLEN-1:0]         rf_wdata;

    logic [NREG-1:0]         busy;
    logic                    wb_err;

    // Pipeline side: drives issues and results, consumes the RF write and busy bits.
    modport master (
        output iss_valid, iss_rd,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  iss_ready, alu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        input  busy, wb_err
    );

    // Arbiter side.
    modport slave (
        input  iss_valid, iss_rd,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output iss_ready, alu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata,
        output busy, wb_err
    );

endinterface : ysyx_22050598_wb_arbiter_if

// File: rtl/ysyx_22050598_pend_cnt.sv
// Per-register pending-write counter: counts issued-but-uncommitted writes.
module ysyx_22050598_pend_cnt
    import ysyx_22050598_wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             busy_o,
    output logic             uflow_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Next count: simultaneous issue and commit cancel; saturate at both ends.
    always_comb begin
        cnt_d   = cnt_q;
        uflow_c = 1'b0;
        if (dec_i && (cnt_q == '0)) begin
            uflow_c = 1'b1;
        end
        unique case ({inc_i, dec_i})
            2'b10: begin
                if (cnt_q != CNT_W'(CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            2'b01: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
        busy_d = (cnt_d != '0);
    end

    // Count and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = busy_q;

endmodule : ysyx_22050598_pend_cnt

// File: rtl/ysyx_22050598_wb_arbiter.sv
// Merges LSU and ALU results onto the single RF write port and tracks
// per-register pending writes so decode can stall on RAW hazards.
module ysyx_22050598_wb_arbiter
    import ysyx_22050598_wb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    ysyx_22050598_wb_arbiter_if.slave   bus
);

    wb_req_t          wb_req_q, wb_req_d;
    logic             wb_vld_q, wb_vld_d;
    logic             rf_wen_q, rf_wen_d;
    logic             wb_err_q, wb_err_d;

    logic [CNT_W-1:0] cnt_w  [NREG];
    logic [NREG-1:0]  busy_w;
    logic [NREG-1:1]  inc_w;
    logic [NREG-1:1]  dec_w;
    logic [NREG-1:1]  uflow_w;

    logic             iss_ready_c;
    logic             iss_fire_c;
    logic             iss_dec_hit_c;

    // LSU has fixed priority; the LSU is never back-pressured.
    assign bus.lsu_ready = 1'b1;
    assign bus.alu_ready = !bus.lsu_valid;

    // Issue is blocked only when the counter is full and no commit frees a slot.
    assign iss_dec_hit_c = wb_vld_q && (wb_req_q.rd == bus.iss_rd);
    assign iss_ready_c   = (bus.iss_rd == '0)
                        || (cnt_w[bus.iss_rd] != CNT_W'(CNT_MAX))
                        || iss_dec_hit_c;
    assign iss_fire_c    = bus.iss_valid && iss_ready_c;
    assign bus.iss_ready = iss_ready_c;

    // x0 never has pending writes.
    assign cnt_w[0]  = '0;
    assign busy_w[0] = 1'b0;

    // One pending counter per architectural register except x0.
    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        assign inc_w[i] = iss_fire_c && (bus.iss_rd == REG_AW'(i));
        assign dec_w[i] = wb_vld_q && (wb_req_q.rd == REG_AW'(i));

        ysyx_22050598_pend_cnt u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc_i   (inc_w[i]),
            .dec_i   (dec_w[i]),
            .cnt_o   (cnt_w[i]),
            .busy_o  (busy_w[i]),
            .uflow_c (uflow_w[i])
        );
    end

    // Select the accepted source and compute the next output stage and error flag.
    always_comb begin
        wb_vld_d = 1'b0;
        wb_req_d = wb_req_q;
        if (bus.lsu_valid) begin
            wb_vld_d = 1'b1;
            wb_req_d = '{rd: bus.lsu_rd, data: bus.lsu_data};
        end else if (bus.alu_valid) begin
            wb_vld_d = 1'b1;
            wb_req_d = '{rd: bus.alu_rd, data: bus.alu_data};
        end
        rf_wen_d = wb_vld_d && (wb_req_d.rd != '0);
        wb_err_d = wb_err_q || (|uflow_w);
    end

    // Output stage and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_vld_q <= 1'b0;
            wb_req_q <= '0;
            rf_wen_q <= 1'b0;
            wb_err_q <= 1'b0;
        end else begin
            wb_vld_q <= wb_vld_d;
            wb_req_q <= wb_req_d;
            rf_wen_q <= rf_wen_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = wb_req_q.rd;
    assign bus.rf_wdata = wb_req_q.data;
    assign bus.busy     = busy_w;
    assign bus.wb_err   = wb_err_q;

endmodule : ysyx_22050598_wb_arbiter
